// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester ports A/B and data-memory array signals of the dmem arbiter
interface dmem_arbiter_if #(parameter int DEPTH_LOG2 = 6);
  logic a_rd, a_wr, a_ready, a_freeze;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic b_rd, b_wr, b_ready;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic mem_we, err;
  modport master(
    output a_rd, a_wr, a_addr, a_wdata, b_rd, b_wr, b_addr, b_wdata, mem_rdata,
    input a_rdata, a_ready, a_freeze, b_rdata, b_ready, mem_addr, mem_wdata, mem_we, err
  );
  modport slave(
    input a_rd, a_wr, a_addr, a_wdata, b_rd, b_wr, b_addr, b_wdata, mem_rdata,
    output a_rdata, a_ready, a_freeze, b_rdata, b_ready, mem_addr, mem_wdata, mem_we, err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin sequencer for the data memory with programmable wait states
// Define DMEM_RANGE_CHECK_EN to flag and suppress accesses outside the mapped window.
module dmem_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'd1024,
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_LOG2 = 6
) (
  input logic clk,
  input logic rst,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic gnt_b, last_b, op_wr, oor;
  logic a_req, b_req, pick_b, sel_wr, sel_oor, rd_cap, unused;
  logic [31:0] sel_addr, sel_wdata, off;
  assign a_req = bus.a_rd | bus.a_wr;
  assign b_req = bus.b_rd | bus.b_wr;
  // A wins a tie unless A was the last port served
  assign pick_b = b_req & (~a_req | ~last_b);
  assign sel_wr = pick_b ? bus.b_wr : bus.a_wr;
  assign sel_addr = pick_b ? bus.b_addr : bus.a_addr;
  assign sel_wdata = pick_b ? bus.b_wdata : bus.a_wdata;
  assign off = sel_addr - BASE_ADDR;
`ifdef DMEM_RANGE_CHECK_EN
  assign sel_oor = off >= (32'd4 << DEPTH_LOG2);
  assign bus.err = state == DONE && oor;
  assign unused = ^off[1:0];
`else
  assign sel_oor = 1'b0;
  assign bus.err = 1'b0;
  assign unused = ^{off[31:DEPTH_LOG2+2], off[1:0]};
`endif
  assign rd_cap = state == ACCESS && cnt == 4'd0 && !op_wr;
  assign bus.mem_we = state == ACCESS && cnt == 4'd0 && op_wr && !oor;
  assign bus.a_ready = state == DONE && !gnt_b;
  assign bus.b_ready = state == DONE && gnt_b;
  assign bus.a_freeze = a_req & ~bus.a_ready;
  always_comb begin
    state_n = (state == IDLE) ? ((a_req | b_req) ? ACCESS : IDLE) :
              (state == ACCESS) ? ((cnt == 4'd0) ? DONE : ACCESS) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      gnt_b <= 1'b0;
      last_b <= 1'b1;
      op_wr <= 1'b0;
      oor <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= 32'd0;
      bus.a_rdata <= 32'd0;
      bus.b_rdata <= 32'd0;
    end else begin
      state <= state_n;
      if (state == IDLE && (a_req | b_req)) begin
        gnt_b <= pick_b;
        last_b <= pick_b;
        op_wr <= sel_wr;
        oor <= sel_oor;
        cnt <= 4'(WAIT_CYCLES);
        bus.mem_addr <= off[DEPTH_LOG2+1:2];
        bus.mem_wdata <= sel_wdata;
      end
      if (state == ACCESS && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (rd_cap && !gnt_b) bus.a_rdata <= oor ? 32'd0 : bus.mem_rdata;
      if (rd_cap && gnt_b) bus.b_rdata <= oor ? 32'd0 : bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized scoreboard bench for dmem_arbiter with a word-array reference model
module tb_dmem_arbiter;
  localparam int W = 2;
  logic clk = 0;
  logic rst = 1;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  dmem_arbiter_if #(.DEPTH_LOG2(6)) bus();
  dmem_arbiter #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(W), .DEPTH_LOG2(6)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [64];
  bit mem_init;
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i) * 32'h9E3779B1;
      mem_init <= 1'b1;
    end else if (bus.mem_we === 1'b1) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  typedef struct {logic rd; logic wr; logic [31:0] addr; logic [31:0] data;} req_t;
  typedef struct {bit port_b; logic [31:0] rdata; int cyc; bit err;} exp_t;
  typedef struct {int idx; logic [31:0] data;} wr_t;
  exp_t sb[$];
  wr_t wq[$];
  exp_t e_m;
  wr_t w_m;
  logic [31:0] ref_mem [64];
  logic [31:0] hold_a, hold_b;
  bit last_b_m;

  function automatic void model(bit pb, req_t r, int rc);
    logic [31:0] off = r.addr - 32'd1024;
    int idx = int'((off / 4) % 64);
    bit out_rng = 0;
`ifdef DMEM_RANGE_CHECK_EN
    out_rng = off >= 32'd256;
`endif
    last_b_m = pb;
    if (r.wr) begin
      if (!out_rng) begin
        ref_mem[idx] = r.data;
        wq.push_back('{idx, r.data});
      end
    end else if (pb) hold_b = out_rng ? 32'd0 : ref_mem[idx];
    else hold_a = out_rng ? 32'd0 : ref_mem[idx];
    sb.push_back('{pb, pb ? hold_b : hold_a, rc, out_rng});
  endfunction

  task automatic chk(string n, logic [31:0] g, logic [31:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", n, g, e, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.a_ready === 1'b1 || bus.b_ready === 1'b1) begin
      total++;
      if (sb.size() == 0 || (bus.a_ready === 1'b1 && bus.b_ready === 1'b1)) begin
        bad++;
        $display("FAIL ready: unexpected pulse a=%b b=%b cyc %0d", bus.a_ready, bus.b_ready, cyc);
      end else begin
        e_m = sb.pop_front();
        if ((bus.b_ready === 1'b1) != e_m.port_b || cyc != e_m.cyc || bus.err !== e_m.err ||
            (e_m.port_b ? bus.b_rdata : bus.a_rdata) !== e_m.rdata) begin
          bad++;
          $display("FAIL ready: got port_b=%b rdata=%h cyc=%0d err=%b want port_b=%b rdata=%h cyc=%0d err=%b",
                   bus.b_ready, e_m.port_b ? bus.b_rdata : bus.a_rdata, cyc, bus.err,
                   e_m.port_b, e_m.rdata, e_m.cyc, e_m.err);
        end
      end
    end else if (bus.err === 1'b1) begin
      total++;
      bad++;
      $display("FAIL err: high without ready at cyc %0d", cyc);
    end
    if (bus.mem_we === 1'b1) begin
      total++;
      if (wq.size() == 0) begin
        bad++;
        $display("FAIL mem_we: unexpected write idx=%0d data=%h cyc %0d", bus.mem_addr, bus.mem_wdata, cyc);
      end else begin
        w_m = wq.pop_front();
        if (int'(bus.mem_addr) != w_m.idx || bus.mem_wdata !== w_m.data) begin
          bad++;
          $display("FAIL mem_we: got idx=%0d data=%h want idx=%0d data=%h", bus.mem_addr, bus.mem_wdata, w_m.idx, w_m.data);
        end
      end
    end
  end

  task automatic run(input req_t ra, input req_t rb);
    int c, left;
    bit a_on, b_on, first_b;
    @(posedge clk); #1;
    {bus.a_rd, bus.a_wr, bus.a_addr, bus.a_wdata} = {ra.rd, ra.wr, ra.addr, ra.data};
    {bus.b_rd, bus.b_wr, bus.b_addr, bus.b_wdata} = {rb.rd, rb.wr, rb.addr, rb.data};
    c = cyc;
    a_on = ra.rd | ra.wr;
    b_on = rb.rd | rb.wr;
    if (!a_on && !b_on) return;
    first_b = b_on && (!a_on || !last_b_m);
    model(first_b, first_b ? rb : ra, c + W + 2);
    if (a_on && b_on) model(!first_b, first_b ? ra : rb, c + 2 * W + 5);
    left = int'(a_on) + int'(b_on);
    for (int k = 0; k < 100 && left > 0; k++) begin
      @(negedge clk);
      if (a_on && bus.a_ready === 1'b1) begin a_on = 0; left--; end
      if (b_on && bus.b_ready === 1'b1) begin b_on = 0; left--; end
      @(posedge clk); #1;
      if (!a_on) {bus.a_rd, bus.a_wr} = 2'b00;
      if (!b_on) {bus.b_rd, bus.b_wr} = 2'b00;
    end
    if (left > 0) begin
      total++;
      bad++;
      $display("FAIL timeout: %0d accesses never completed", left);
      {bus.a_rd, bus.a_wr, bus.b_rd, bus.b_wr} = 4'b0;
    end
  endtask

  function automatic req_t rnd();
    req_t r;
    r.rd = 1'($urandom_range(0, 1));
    r.wr = ($urandom % 3) == 0;
    r.addr = ($urandom % 8 == 0) ? 32'd1024 - 32'($urandom_range(1, 16)) :
             32'd1024 + 32'($urandom_range(0, 280));
    r.data = $urandom;
    return r;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    {bus.a_rd, bus.a_wr, bus.b_rd, bus.b_wr} = 4'b0;
    {bus.a_addr, bus.a_wdata, bus.b_addr, bus.b_wdata} = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'(i) * 32'h9E3779B1;
    hold_a = 0;
    hold_b = 0;
    last_b_m = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", 32'(bus.a_ready), 0);
    chk("rst_b_ready", 32'(bus.b_ready), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_a_rdata", bus.a_rdata, 0);
    chk("rst_b_rdata", bus.b_rdata, 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    @(posedge clk); #1;
    rst = 0;
    // single read with freeze profile
    @(posedge clk); #1;
    bus.a_rd = 1;
    bus.a_addr = 32'd1032;
    c = cyc;
    model(0, '{1'b1, 1'b0, 32'd1032, 32'd0}, c + W + 2);
    for (int k = 0; k <= W + 2; k++) begin
      @(negedge clk);
      chk("freeze", 32'(bus.a_freeze), 32'(k < W + 2));
      if (k == 1) chk("mem_addr", 32'(bus.mem_addr), 2);
    end
    @(posedge clk); #1;
    bus.a_rd = 0;
    run('{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF}, '{1'b0, 1'b0, 32'd0, 32'd0});
    run('{1'b1, 1'b0, 32'd1028, 32'd0}, '{1'b0, 1'b0, 32'd0, 32'd0});
    chk("wr_rd", bus.a_rdata, 32'hDEADBEEF);
    run('{1'b1, 1'b1, 32'd1040, 32'h0BADF00D}, '{1'b1, 1'b0, 32'd1040, 32'd0});
    for (int i = 0; i < 4; i++)
      run('{1'b1, 1'b0, 32'd1024 + 32'(8 * i), 32'd0}, '{1'b1, 1'b0, 32'd1100 + 32'(4 * i), 32'd0});
    // reset abandons a pending B write
    @(posedge clk); #1;
    bus.b_wr = 1;
    bus.b_addr = 32'd1036;
    bus.b_wdata = 32'h12345678;
    @(posedge clk); #1;
    rst = 1;
    bus.b_wr = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("mid_rst_b_ready", 32'(bus.b_ready), 0);
    chk("mid_rst_mem_we", 32'(bus.mem_we), 0);
    chk("mid_rst_a_rdata", bus.a_rdata, 0);
    chk("mid_rst_b_rdata", bus.b_rdata, 0);
    hold_a = 0;
    hold_b = 0;
    last_b_m = 1;
    run('{1'b0, 1'b0, 32'd0, 32'd0}, '{1'b1, 1'b0, 32'd1036, 32'd0});
    run('{1'b1, 1'b0, 32'd1036, 32'd0}, '{1'b1, 1'b0, 32'd1032, 32'd0});
    run('{1'b0, 1'b1, 32'd1024 + 32'd256, 32'hCAFEF00D}, '{1'b0, 1'b0, 32'd0, 32'd0});
    run('{1'b1, 1'b0, 32'd1024, 32'd0}, '{1'b0, 1'b0, 32'd0, 32'd0});
    repeat (60) run(rnd(), rnd());
    repeat (4) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    chk("wq_empty", 32'(wq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the 64-word data memory between two requesters: port A (pipeline MEM stage) and port B (loader/debug).
- Translates byte addresses to word indices and inserts programmable wait states.
- Returns read data with a one-cycle ready pulse, and produces the pipeline freeze signal.
- Sits between the MEM stage and the data-memory array. The array has a synchronous write and a combinational read.

Parameters:
- BASE_ADDR, 32'd1024, byte address mapped to word 0.
- WAIT_CYCLES, 2, extra memory cycles per access (0..15).
- DEPTH_LOG2, 6, word-index width (64 words).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- a_rd  in  1  port A read request.
- a_wr  in  1  port A write request.
- a_addr  in  32  port A byte address.
- a_wdata  in  32  port A write data.
- a_rdata  out  32  port A read data.
- a_ready  out  1  port A access complete (one-cycle pulse).
- a_freeze  out  1  pipeline stall: (a_rd|a_wr) & ~a_ready.
- b_rd, b_wr, b_addr, b_wdata, b_rdata, b_ready: same as port A, for port B.
- mem_addr  out  DEPTH_LOG2  word index to the array.
- mem_wdata  out  32  write data to the array.
- mem_we  out  1  array write enable.
- mem_rdata  in  32  array combinational read data.
- err  out  1  out-of-range flag (see Optional Feature).

Behaviour:
- Reset (clk edge with rst=1):
  - FSM goes to IDLE.
  - mem_we=0, a_ready=b_ready=0, err=0.
  - a_rdata=b_rdata=0, mem_addr=0, mem_wdata=0, cnt=0.
  - last_grant=B, so A wins the first tie.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any request is present, grant it, register op/addr/wdata, load cnt=WAIT_CYCLES, and go to ACCESS.
  - If both ports request, grant the port that is not last_grant, then update last_grant.
- ACCESS:
  - mem_addr and mem_wdata are driven from the registers.
  - While cnt>0: decrement cnt; mem_we=0.
  - When cnt==0:
    - Write: mem_we=1 for exactly this cycle.
    - Read: mem_rdata is captured into the granted port's rdata at the clock edge.
  - Then go to DONE.
- DONE: granted port's ready=1 for one cycle; go to IDLE.
- Latency:
  - Request first seen in IDLE at cycle n; ready is high in cycle n+WAIT_CYCLES+2.
  - WAIT_CYCLES=0 gives ready at n+2.
  - Back-to-back accesses have a minimum spacing of WAIT_CYCLES+3 cycles.
- Handshake:
  - A requester holds rd/wr/addr/wdata stable until its ready pulse.
  - Request signals changing after the grant are ignored.
  - The requester deasserts or presents a new request in the cycle after ready.
- rd and wr both high on one port: treated as a write.
- rdata of a port holds its last read value. It is not cleared by writes or by accesses on the other port.
- Address translation:
  - off = addr - BASE_ADDR, computed in 32-bit modulo arithmetic.
  - mem_addr = off[DEPTH_LOG2+1:2]; bits [1:0] are ignored.
- Reset mid-operation: the access is abandoned with no ready pulse. A write is not performed unless its mem_we cycle already occurred.
- mem_we is never high outside ACCESS with cnt==0.

Optional Feature:
- Macro: DMEM_RANGE_CHECK_EN.
- When defined:
  - At grant, if off >= 4<<DEPTH_LOG2 (addr below BASE_ADDR also wraps large), the access is out of range.
  - For an out-of-range write, mem_we stays 0.
  - For an out-of-range read, rdata is 32'h0 instead of mem_rdata.
  - err=1 during that access's DONE cycle only; the access still completes with ready.
- When undefined:
  - No check is made; the index wraps modulo 64 words.
  - err is tied to 0.

Test Plan:
- Single read, WAIT_CYCLES=2: a_rd=1 with a_addr=32'd1032 at cycle 0 -> mem_addr=2; a_ready pulses in cycle 4; a_rdata=mem[2]; a_freeze=1 in cycles 0-3.
- Write then read: a_wr with a_addr=1028 and a_wdata=32'hDEADBEEF -> mem_we=1 exactly once, with mem_addr=1. A following a_rd at 1028 -> a_rdata=32'hDEADBEEF.
- Simultaneous requests out of reset: A and B both read -> A is granted first, then B; a_ready precedes b_ready by WAIT_CYCLES+3 cycles.
- Repeated ties with both ports requesting continuously -> grants alternate A, B, A, B; neither port starves.
- rst=1 during ACCESS of a B write, before the mem_we cycle -> no mem_we and no b_ready; the FSM is in IDLE on the next cycle.
- Range check with DMEM_RANGE_CHECK_EN defined, a_wr at addr 32'd1024+256 -> mem_we stays 0; err=1 and a_ready=1 in the same cycle. With the macro undefined, the same write goes to word 0.
